axi_write_response_tracker: RTL
===============================

Name: axi_write_response_tracker

Overview:
- Master-side consumer of the AXI B (write response) channel.
- Counts write addresses accepted on AW and retires them as B beats arrive; drives bready.
- Gates new AW issue when MAX_OUTSTANDING writes are in flight.
- Flags non-OKAY responses, unexpected responses and response timeouts to the write master.

Parameters:
MAX_OUTSTANDING, 16, max writes in flight (power of two not required, >=1)
CNT_W, $clog2(MAX_OUTSTANDING+1), width of outstanding count
TIMEOUT_CYCLES, 1024, cycles without a B beat while writes are outstanding before fault (>=2)
TO_W, $clog2(TIMEOUT_CYCLES), width of timeout counter

Ports:
clk  in  1  clock
i_reset  in  1  asynchronous reset, active-low
i_awvalid  in  1  AW valid seen on bus
i_awready  in  1  AW ready seen on bus
i_bvalid  in  1  B valid from slave
i_bresp  in  2  B response code
i_err_clear  in  1  one-cycle pulse; clears sticky flags and exits FAULT
o_bready  out  1  B ready to slave
o_aw_allow  out  1  master may assert awvalid
o_outstanding  out  CNT_W  writes in flight
o_idle  out  1  outstanding==0 and state IDLE
o_err  out  1  sticky: a SLVERR/DECERR was received
o_err_resp  out  2  code of first error since last clear
o_err_count  out  8  error responses since clear, saturates at 255
o_unexpected_b  out  1  sticky: B beat with zero outstanding
o_aw_overflow  out  1  sticky: AW handshake while count==MAX
o_timeout  out  1  sticky: timeout fired

Behaviour:
- Reset (i_reset low, async): all outputs 0, count 0, timeout counter 0, state IDLE. o_bready registered, goes 1 on first clk edge after reset release.
- aw_fire = i_awvalid & i_awready; b_fire = i_bvalid & o_bready.
- Count update, registered, visible one cycle after the fire:
  - aw_fire only: +1.
  - b_fire only: -1.
  - both same cycle: unchanged.
  - aw_fire at count==MAX: increment suppressed, o_aw_overflow set (b_fire in the same cycle still decrements).
  - b_fire at count==0: stays 0, o_unexpected_b set; an aw_fire in the same cycle still yields count 1.
- o_bready is 1 in all states after reset, including FAULT; responses are always drained.
- Response check on b_fire:
  - i_bresp 0 (OKAY) or 1 (EXOKAY) is good.
  - 2 or 3 sets o_err; o_err_resp captures the code only if o_err was 0; o_err_count += 1, saturating.
- o_aw_allow = (state != FAULT) & (count < MAX). Combinational from registers only, no input paths.
- Timeout counter:
  - Cleared when b_fire or count==0; otherwise increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no b_fire that cycle: state -> FAULT, o_timeout set; counter holds.
- FSM (registered):
  - IDLE: count==0. -> BUSY when next count>0.
  - BUSY: 0<count<MAX. -> FULL when next count==MAX; -> IDLE when next count==0; -> FAULT on timeout.
  - FULL: count==MAX, aw_allow 0. -> BUSY on b_fire without aw_fire; -> FAULT on timeout.
  - FAULT: aw_allow 0, counting and B draining continue. Leaves only on i_err_clear, to IDLE/BUSY/FULL per current count.
- i_err_clear:
  - Clears o_err, o_err_resp, o_err_count, o_unexpected_b, o_aw_overflow, o_timeout and the timeout counter.
  - An error b_fire in the same cycle wins: flag set, count = 1, resp captured.
- o_idle = (state==IDLE).
- Reset mid-operation: all in-flight state discarded, nothing retained.

Test Plan:
- Reset, then 3 back-to-back aw_fire, then 3 OKAY b_fire -> o_outstanding 1,2,3,2,1,0; o_idle 1 at end; no flags.
- MAX=16: 16 aw_fire with bvalid 0 -> o_aw_allow 0 the cycle after count hits 16; a 17th forced aw_fire sets o_aw_overflow and count stays 16; one b_fire -> aw_allow 1.
- aw_fire and b_fire in the same cycle at count 5 -> count stays 5; at count 0 -> count 1 and o_unexpected_b 0.
- B responses SLVERR then DECERR then OKAY -> o_err 1, o_err_resp 2, o_err_count 2; i_err_clear -> all 0.
- TIMEOUT_CYCLES=8, 1 outstanding, no B -> o_timeout and FAULT after 7 cycles, aw_allow 0. B then arrives -> count 0, still FAULT. i_err_clear -> IDLE, aw_allow 1.
- Assert i_reset low mid-burst at count 4 -> all outputs 0 immediately (async); o_bready 1 one edge after release.

Source files
------------

// File: rtl/axi_write_response_tracker.sv
`default_nettype none
// ==========================================================================
// axi_write_response_tracker : AXI B-channel consumer, outstanding-write
// gate and response/timeout fault flags.                 Revision: 1.0
// ==========================================================================
module axi_write_response_tracker #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int TO_W            = $clog2(TIMEOUT_CYCLES)
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_awvalid,
  input  logic             i_awready,
  input  logic             i_bvalid,
  input  logic [1:0]       i_bresp,
  input  logic             i_err_clear,
  output logic             o_bready,
  output logic             o_aw_allow,
  output logic [CNT_W-1:0] o_outstanding,
  output logic             o_idle,
  output logic             o_err,
  output logic [1:0]       o_err_resp,
  output logic [7:0]       o_err_count,
  output logic             o_unexpected_b,
  output logic             o_aw_overflow,
  output logic             o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] C_MAX     = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TO_W-1:0]  C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  C_TO_ARM  = TO_W'(TIMEOUT_CYCLES - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             bready_q;
  logic             err_q, err_d;
  logic [1:0]       err_resp_q, err_resp_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             unexp_q, unexp_d;
  logic             ovf_q, ovf_d;
  logic             timeout_q, timeout_d;

  logic aw_fire, b_fire, cnt_full, cnt_zero, to_fire, bad_resp;

  always_comb begin
    aw_fire  = i_awvalid & i_awready;
    b_fire   = i_bvalid & bready_q;
    cnt_full = (count_q == C_MAX);
    cnt_zero = (count_q == '0);
    bad_resp = b_fire & ((i_bresp == 2'd2) | (i_bresp == 2'd3));

    count_d = count_q;
    if (aw_fire && !cnt_full) count_d = count_d + CNT_W'(1);
    if (b_fire && !cnt_zero)  count_d = count_d - CNT_W'(1);

    // Fires on the cycle the counter steps onto its last value, then keeps
    // re-firing while it holds there; a clear pulse always wins.
    to_fire = !i_err_clear && !cnt_zero && !b_fire && (to_q >= C_TO_ARM);
    if (i_err_clear || b_fire || cnt_zero) to_d = '0;
    else if (to_fire)                      to_d = C_TO_LAST;
    else                                   to_d = to_q + TO_W'(1);

    if (state_q == S_FAULT && !i_err_clear) state_d = S_FAULT;
    else if (to_fire)                       state_d = S_FAULT;
    else if (count_d == '0)                 state_d = S_IDLE;
    else if (count_d == C_MAX)              state_d = S_FULL;
    else                                    state_d = S_BUSY;

    err_d       = err_q;
    err_resp_d  = err_resp_q;
    err_count_d = err_count_q;
    if (i_err_clear) begin
      err_d       = bad_resp;
      err_resp_d  = bad_resp ? i_bresp : 2'd0;
      err_count_d = bad_resp ? 8'd1 : 8'd0;
    end else if (bad_resp) begin
      err_d = 1'b1;
      if (!err_q) err_resp_d = i_bresp;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    unexp_d   = (b_fire & cnt_zero & ~aw_fire) | (unexp_q & ~i_err_clear);
    ovf_d     = (aw_fire & cnt_full) | (ovf_q & ~i_err_clear);
    timeout_d = to_fire | (timeout_q & ~i_err_clear);
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      to_q        <= '0;
      bready_q    <= 1'b0;
      err_q       <= 1'b0;
      err_resp_q  <= 2'd0;
      err_count_q <= 8'd0;
      unexp_q     <= 1'b0;
      ovf_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      to_q        <= to_d;
      bready_q    <= 1'b1;
      err_q       <= err_d;
      err_resp_q  <= err_resp_d;
      err_count_q <= err_count_d;
      unexp_q     <= unexp_d;
      ovf_q       <= ovf_d;
      timeout_q   <= timeout_d;
    end
  end

  // bready_q doubles as "out of reset" so every output reads 0 while reset is held.
  assign o_bready       = bready_q;
  assign o_aw_allow     = bready_q & (state_q != S_FAULT) & ~cnt_full;
  assign o_idle         = bready_q & (state_q == S_IDLE);
  assign o_outstanding  = count_q;
  assign o_err          = err_q;
  assign o_err_resp     = err_resp_q;
  assign o_err_count    = err_count_q;
  assign o_unexpected_b = unexp_q;
  assign o_aw_overflow  = ovf_q;
  assign o_timeout      = timeout_q;

endmodule
`default_nettype wire
